// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Purpose:
//    Round-robin arbiter sharing one synchronous FIFO write port between
//    NUM_REQ producers. A registered one-hot grant is held for at most
//    MAX_BURST accepted beats, then released so the next producer (searching
//    upward from the one after the last owner) gets a turn. FIFO full
//    stalls the current owner with zero latency and does not cost a beat.
//    A release is always followed by one dead IDLE cycle.
//
// Parameters:
//    NUM_REQ    number of producers (2..8)
//    DATA_W     beat width, equal to the FIFO data width
//    MAX_BURST  accepted beats per grant before forced release (1..15)
//
// Ports:
//    clk           clock, rising edge
//    reset_i       asynchronous active-high reset
//    req_valid_i   per-producer valid
//    req_data_i    packed producer data, producer k at [k*DATA_W +: DATA_W]
//    req_ready_o   per-producer accept (beat moves on valid & ready)
//    fifo_full_i   FIFO full flag
//    fifo_wr_en_o  FIFO write enable
//    fifo_data_o   FIFO write data (0 when idle)
//    grant_o       registered one-hot grant, 0 when idle
//    busy_o        high while a grant is held
//
// Optional feature (macro FIFO_ARB_STATS_EN):
//    stat_beats_o  NUM_REQ saturating 16-bit accepted-beat counters
//    stat_stall_o  saturating 16-bit count of granted cycles stalled by full
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 3,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      reset_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      fifo_full_i,
   output logic                      fifo_wr_en_o,
   output logic [DATA_W-1:0]         fifo_data_o,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic                      busy_o
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]     stat_beats_o,
   output logic [15:0]               stat_stall_o
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_gidx;
   logic [IDX_W-1:0]   w_gidx_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   logic [IDX_W-1:0]   w_rr_ptr_nxt;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] w_grant_nxt;
   logic [CNT_W-1:0]   r_burst_cnt;
   logic [CNT_W-1:0]   w_burst_cnt_nxt;
   logic [IDX_W-1:0]   w_winner;
   logic               w_found;
   logic               w_busy;
   logic               w_gvalid;
   logic               w_accept;
   logic               w_release;

   // First valid requester at or above rr_ptr, wrapping to 0.
   always_comb begin : p_rr_search
      int unsigned v_idx;
      w_winner = '0;
      w_found  = 1'b0;
      v_idx    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
         if (!w_found && req_valid_i[v_idx]) begin
            w_found  = 1'b1;
            w_winner = IDX_W'(v_idx);
         end
      end
   end

   assign w_busy   = (r_state == S_GRANT);
   assign w_gvalid = req_valid_i[r_gidx];
   assign w_accept = w_busy && w_gvalid && !fifo_full_i;

   // A stall (full) never releases, even if the owner has gone idle.
   assign w_release = w_busy &&
                      ((w_accept && (r_burst_cnt == CNT_W'(MAX_BURST - 1))) ||
                       (!fifo_full_i && !w_gvalid));

   // Write path is purely combinational from the held grant.
   always_comb begin
      req_ready_o  = '0;
      fifo_wr_en_o = 1'b0;
      fifo_data_o  = '0;
      if (w_busy) begin
         req_ready_o[r_gidx] = !fifo_full_i;
         fifo_wr_en_o        = w_gvalid && !fifo_full_i;
         fifo_data_o         = req_data_i[r_gidx*DATA_W +: DATA_W];
      end
   end

   assign grant_o = r_grant;
   assign busy_o  = w_busy;

   always_comb begin
      w_state_nxt     = r_state;
      w_gidx_nxt      = r_gidx;
      w_grant_nxt     = r_grant;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_burst_cnt_nxt = r_burst_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt     = S_GRANT;
               w_gidx_nxt      = w_winner;
               w_grant_nxt     = NUM_REQ'(1) << w_winner;
               w_burst_cnt_nxt = '0;
            end
         end
         S_GRANT: begin
            if (w_accept) begin
               w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
            if (w_release) begin
               w_state_nxt  = S_IDLE;
               w_grant_nxt  = '0;
               w_rr_ptr_nxt = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= S_IDLE;
         r_gidx      <= '0;
         r_grant     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_gidx      <= w_gidx_nxt;
         r_grant     <= w_grant_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [15:0] r_stat_beats [NUM_REQ];
   logic [15:0] r_stat_stall;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            r_stat_beats[k] <= '0;
         end
         r_stat_stall <= '0;
      end else begin
         if (w_accept) begin
            r_stat_beats[r_gidx] <= sat_inc(r_stat_beats[r_gidx]);
         end
         if (w_busy && fifo_full_i && w_gvalid) begin
            r_stat_stall <= sat_inc(r_stat_stall);
         end
      end
   end

   always_comb begin
      stat_beats_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         stat_beats_o[k*16 +: 16] = r_stat_beats[k];
      end
   end

   assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed scenarios followed by a randomized run, every cycle compared
// against a transaction-level model of the arbiter: who owns the port, how
// many beats it has moved, and where the next search starts.
// Optional statistics ports are exercised when FIFO_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 3;
   localparam int MAX_BURST = 4;

   logic                      clk = 1'b0;
   logic                      reset_i;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*DATA_W-1:0] req_data_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      fifo_full_i;
   logic                      fifo_wr_en_o;
   logic [DATA_W-1:0]         fifo_data_o;
   logic [NUM_REQ-1:0]        grant_o;
   logic                      busy_o;
`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*16-1:0]     stat_beats_o;
   logic [15:0]               stat_stall_o;
`endif

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .DATA_W   (DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk         (clk),
      .reset_i     (reset_i),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .fifo_full_i (fifo_full_i),
      .fifo_wr_en_o(fifo_wr_en_o),
      .fifo_data_o (fifo_data_o),
      .grant_o     (grant_o),
      .busy_o      (busy_o)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stat_beats_o(stat_beats_o),
      .stat_stall_o(stat_stall_o)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: owner index (-1 = nobody), beats moved by owner, search start.
   int m_owner;
   int m_beats;
   int m_next;
   int m_stat_beats [NUM_REQ];
   int m_stat_stall;

   logic [DATA_W-1:0]  wlog [$];
   logic [NUM_REQ-1:0] glog [$];
   logic [NUM_REQ-1:0] prev_grant;
   logic [NUM_REQ-1:0] last_grant;
   logic [NUM_REQ-1:0] last_ready;
   logic               last_wr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_beats = 0;
      m_next  = 0;
      for (int k = 0; k < NUM_REQ; k++) m_stat_beats[k] = 0;
      m_stat_stall = 0;
   endtask

   task automatic check_outputs();
      logic [NUM_REQ-1:0] eg;
      logic [NUM_REQ-1:0] er;
      logic               ew;
      logic [DATA_W-1:0]  ed;
      if (reset_i) model_reset();
      eg = '0; er = '0; ew = 1'b0; ed = '0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         er[m_owner] = !fifo_full_i;
         ew          = req_valid_i[m_owner] && !fifo_full_i;
         ed          = req_data_i[m_owner*DATA_W +: DATA_W];
      end
      chk("grant", 64'(grant_o), 64'(eg));
      chk("ready", 64'(req_ready_o), 64'(er));
      chk("wr_en", 64'(fifo_wr_en_o), 64'(ew));
      chk("data", 64'(fifo_data_o), 64'(ed));
      chk("busy", 64'(busy_o), 64'(m_owner >= 0));
`ifdef FIFO_ARB_STATS_EN
      for (int k = 0; k < NUM_REQ; k++)
         chk($sformatf("stat_beats%0d", k), 64'(stat_beats_o[k*16 +: 16]), 64'(m_stat_beats[k]));
      chk("stat_stall", 64'(stat_stall_o), 64'(m_stat_stall));
`endif
      if (fifo_wr_en_o) wlog.push_back(fifo_data_o);
      if (grant_o != '0 && grant_o != prev_grant) glog.push_back(grant_o);
      prev_grant = grant_o;
      last_grant = grant_o;
      last_ready = req_ready_o;
      last_wr    = fifo_wr_en_o;
   endtask

   task automatic model_edge();
      bit moved;
      if (reset_i) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m_owner < 0 && req_valid_i[(m_next + i) % NUM_REQ]) begin
               m_owner = (m_next + i) % NUM_REQ;
               m_beats = 0;
            end
         end
      end else begin
         moved = req_valid_i[m_owner] && !fifo_full_i;
         if (fifo_full_i && req_valid_i[m_owner] && m_stat_stall < 65535) m_stat_stall++;
         if (moved) begin
            if (m_stat_beats[m_owner] < 65535) m_stat_beats[m_owner]++;
            m_beats++;
         end
         if ((moved && m_beats == MAX_BURST) || (!fifo_full_i && !req_valid_i[m_owner])) begin
            m_next  = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
         end
      end
   endtask

   // Inputs are changed just after a rising edge; outputs checked at the
   // falling edge, model advanced at the next rising edge.
   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      req_valid_i = '0;
      fifo_full_i = 1'b0;
      step();
      reset_i = 1'b0;
      wlog.delete();
      glog.delete();
   endtask

   localparam logic [NUM_REQ-1:0] EXP3 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   localparam logic [NUM_REQ-1:0] EXP5 [3] = '{4'b0100, 4'b1000, 4'b0001};

   initial begin
      int nxt;
      reset_i     = 1'b1;
      req_valid_i = '0;
      req_data_i  = '0;
      fifo_full_i = 1'b0;
      prev_grant  = '0;
      model_reset();
      #1;

      // 1: reset held with every requester valid
      req_valid_i = '1;
      repeat (3) step();
      chk("t1_grant", 64'(last_grant), 64'(0));
      reset_i = 1'b0;

      // 2: single requester, data 0..7 advanced on acceptance
      do_reset();
      nxt = 0;
      req_valid_i = 4'b0010;
      for (int c = 0; c < 40 && nxt < 8; c++) begin
         req_data_i = '0;
         req_data_i[1*DATA_W +: DATA_W] = DATA_W'(nxt);
         step();
         if (last_ready[1]) nxt++;
      end
      req_valid_i = '0;
      step();
      chk("t2_count", 64'(wlog.size()), 64'(8));
      for (int i = 0; i < wlog.size() && i < 8; i++)
         chk($sformatf("t2_word%0d", i), 64'(wlog[i]), 64'(i));
      chk("t2_grants", 64'(glog.size()), 64'(2));

      // 3: all requesters valid, req k presents value k
      do_reset();
      for (int k = 0; k < NUM_REQ; k++) req_data_i[k*DATA_W +: DATA_W] = DATA_W'(k);
      req_valid_i = '1;
      repeat (22) step();
      req_valid_i = '0;
      chk("t3_ngrant", 64'(glog.size() >= 5), 64'(1));
      for (int i = 0; i < 5 && i < glog.size(); i++)
         chk($sformatf("t3_grant%0d", i), 64'(glog[i]), 64'(EXP3[i]));
      chk("t3_nwrite", 64'(wlog.size() >= 16), 64'(1));
      for (int i = 0; i < 16 && i < wlog.size(); i++)
         chk($sformatf("t3_word%0d", i), 64'(wlog[i]), 64'(i / 4));

      // 4: FIFO full for 3 cycles after 2 beats
      do_reset();
      req_valid_i = 4'b0001;
      step();
      repeat (2) step();
      fifo_full_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_stall_wr", 64'(last_wr), 64'(0));
         chk("t4_stall_rdy", 64'(last_ready), 64'(0));
         chk("t4_stall_gnt", 64'(last_grant), 64'(4'b0001));
      end
      fifo_full_i = 1'b0;
      repeat (2) step();
      chk("t4_beat4_wr", 64'(last_wr), 64'(1));
      step();
      chk("t4_released", 64'(last_grant), 64'(0));
      chk("t4_total", 64'(wlog.size()), 64'(4));
      req_valid_i = '0;

      // 5: req 2 drops after one beat while 0 and 3 wait
      do_reset();
      req_valid_i = 4'b0100;
      step();
      req_valid_i = 4'b1101;
      step();
      req_valid_i = 4'b1001;
      repeat (8) step();
      chk("t5_ngrant", 64'(glog.size()), 64'(3));
      for (int i = 0; i < 3 && i < glog.size(); i++)
         chk($sformatf("t5_grant%0d", i), 64'(glog[i]), 64'(EXP5[i]));
`ifdef FIFO_ARB_STATS_EN
      chk("t5_stat2", 64'(stat_beats_o[2*16 +: 16]), 64'(1));
`endif
      req_valid_i = '0;

      // 6: reset lands during beat 3 of req 1
      do_reset();
      req_valid_i = 4'b0010;
      repeat (3) step();
      chk("t6_pre_wr", 64'(fifo_wr_en_o), 64'(1));
      #2;
      reset_i = 1'b1;
      #1;
      check_outputs();
      step();
      reset_i = 1'b0;
      req_valid_i = 4'b0011;
      repeat (2) step();
      chk("t6_first_grant", 64'(last_grant), 64'(4'b0001));
      req_valid_i = '0;

      // Randomized traffic with occasional full and reset
      do_reset();
      for (int c = 0; c < 600; c++) begin
         req_valid_i = NUM_REQ'($urandom);
         req_data_i  = (NUM_REQ*DATA_W)'($urandom);
         fifo_full_i = ($urandom_range(0, 3) == 0);
         reset_i     = ($urandom_range(0, 99) == 0);
         step();
      end
      reset_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
